// File: rtl/sub_part.sv
// Two-stage registered PD velocity controller for the BLDC speed loop.
// Optional macro SUB_PART_VALID_EN adds the out_valid port and the v1/v2 valid pipeline.
module sub_part #(
    parameter int unsigned SHIFT = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [7:0]        target_vel,
    input  logic [7:0]        current_vel,
    input  logic [3:0]        Kp,
    input  logic [3:0]        Kd,
    output logic signed [8:0] out_vel
`ifdef SUB_PART_VALID_EN
    ,
    output logic              out_valid
`endif
);

    localparam int unsigned E_W   = 9;
    localparam int unsigned D_W   = 10;
    localparam int unsigned ACC_W = 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 16'sd255;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -16'sd256;

    logic signed [E_W-1:0]   r_e;
    logic signed [D_W-1:0]   r_d;
    logic signed [E_W-1:0]   r_prev_e;
    logic signed [E_W-1:0]   r_out_vel;

    logic signed [E_W-1:0]   w_e;
    logic signed [D_W-1:0]   w_d;
    logic signed [ACC_W-1:0] w_kp;
    logic signed [ACC_W-1:0] w_kd;
    logic signed [ACC_W-1:0] w_e_ext;
    logic signed [ACC_W-1:0] w_d_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [E_W-1:0]   w_sat;

    // Stage-1 error and derivative against the last enabled sample
    assign w_e = $signed({1'b0, target_vel}) - $signed({1'b0, current_vel});
    assign w_d = {w_e[E_W-1], w_e} - {r_prev_e[E_W-1], r_prev_e};

    // Stage-2 PD sum; 16 bits covers 15*255 + 15*510 without overflow
    assign w_kp    = {12'b0, Kp};
    assign w_kd    = {12'b0, Kd};
    assign w_e_ext = {{(ACC_W-E_W){r_e[E_W-1]}}, r_e};
    assign w_d_ext = {{(ACC_W-D_W){r_d[D_W-1]}}, r_d};
    assign w_sum   = (w_kp * w_e_ext) + (w_kd * w_d_ext);
    assign w_shift = w_sum >>> SHIFT;

    always_comb begin
        w_sat = w_shift[E_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[E_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[E_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_e       <= '0;
            r_d       <= '0;
            r_prev_e  <= '0;
            r_out_vel <= '0;
        end else if (EN) begin
            r_e       <= w_e;
            r_d       <= w_d;
            r_prev_e  <= w_e;
            r_out_vel <= w_sat;
        end
    end

    assign out_vel = r_out_vel;

`ifdef SUB_PART_VALID_EN
    logic r_v1;
    logic r_v2;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (EN) begin
            r_v1 <= 1'b1;
            r_v2 <= r_v1;
        end
    end

    assign out_valid = r_v2;
`endif

endmodule

// File: tb/tb_sub_part.sv
// Scoreboard bench for sub_part: sample-history reference model plus directed literal checks.
module tb_sub_part;

    localparam int SHIFT = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              EN;
    logic [7:0]        target_vel;
    logic [7:0]        current_vel;
    logic [3:0]        Kp;
    logic [3:0]        Kd;
    logic signed [8:0] out_vel;
`ifdef SUB_PART_VALID_EN
    logic              out_valid;
`endif

    sub_part #(.SHIFT(SHIFT)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .target_vel (target_vel),
        .current_vel(current_vel),
        .Kp         (Kp),
        .Kd         (Kd),
        .out_vel    (out_vel)
`ifdef SUB_PART_VALID_EN
        ,
        .out_valid  (out_valid)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int vel;
        bit vld;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   step_no = 0;

    // Model state: errors of every enabled sample since the last reset
    int   hist[$];
    int   m_out = 0;

    function automatic int floor_div(input int s);
        int div;
        int q;
        div = 1 << SHIFT;
        q = s / div;
        if ((s < 0) && ((s % div) != 0)) q = q - 1;
        return q;
    endfunction

    function automatic int sat9(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    // Drive one edge's inputs and push the predicted post-edge output
    task automatic step(input bit rst_n, input bit en, input int tgt, input int cur,
                        input int kp, input int kd);
        exp_t x;
        int n;
        int e;
        int prev;
        @(negedge CLK);
        RST_N       = rst_n;
        EN          = en;
        target_vel  = 8'(tgt);
        current_vel = 8'(cur);
        Kp          = 4'(kp);
        Kd          = 4'(kd);
        if (!rst_n) begin
            hist.delete();
            m_out = 0;
        end else if (en) begin
            hist.push_back(tgt - cur);
            n = hist.size();
            if (n >= 2) begin
                e     = hist[n-2];
                prev  = (n >= 3) ? hist[n-3] : 0;
                m_out = sat9(floor_div(kp * e + kd * (e - prev)));
            end
        end
        step_no++;
        x.vel = m_out;
        x.vld = (hist.size() >= 2);
        x.idx = step_no;
        exp_q.push_back(x);
    endtask

    // Compare against a literal value taken straight from the worked examples
    task automatic chk(input string name, input int want);
        @(posedge CLK);
        #2;
        checks++;
        if (int'(out_vel) != want) begin
            fails++;
            $display("FAIL %s: out_vel=%0d expected %0d", name, int'(out_vel), want);
        end
    endtask

    // Monitor: one prediction per clock edge
    initial begin
        exp_t x;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (int'(out_vel) != x.vel) begin
                    fails++;
                    $display("FAIL sb_vel step%0d: out_vel=%0d expected %0d", x.idx, int'(out_vel), x.vel);
                end
`ifdef SUB_PART_VALID_EN
                checks++;
                if (out_valid != x.vld) begin
                    fails++;
                    $display("FAIL sb_valid step%0d: out_valid=%0d expected %0d", x.idx, out_valid, x.vld);
                end
`endif
            end
        end
    end

    task automatic do_reset(input int edges);
        for (int i = 0; i < edges; i++) step(1'b0, 1'b1, $urandom_range(255), $urandom_range(255),
                                             $urandom_range(15), $urandom_range(15));
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; target_vel = '0; current_vel = '0; Kp = '0; Kd = '0;

        do_reset(3);
        chk("reset_zero", 0);

        step(1, 1, 40, 45, 12, 6);
        step(1, 1, 40, 45, 12, 6);
        chk("pd_first", -23);
        step(1, 1, 40, 45, 12, 6);
        chk("pd_steady", -15);
        step(1, 1, 40, 45, 12, 6);
        chk("pd_hold", -15);
        for (int i = 0; i < 5; i++) step(1, 0, 100, 45, 12, 6);
        chk("en_freeze", -15);
        step(1, 1, 100, 45, 12, 6);
        chk("reenable_s1", -15);
        step(1, 1, 100, 45, 12, 6);
        chk("reenable_out", 255);

        do_reset(1);
        step(1, 1, 255, 0, 15, 15);
        step(1, 1, 255, 0, 15, 15);
        chk("sat_pos", 255);

        do_reset(1);
        step(1, 1, 0, 255, 15, 15);
        step(1, 1, 0, 255, 15, 15);
        chk("sat_neg", -256);

        for (int kd = 0; kd <= 2; kd += 2) begin
            do_reset(1);
            for (int i = 0; i < 3; i++) step(1, 1, 40, 45, 12, 6);
            do_reset(1);
            step(1, 1, 50, 40, 4, kd);
            step(1, 1, 50, 40, 4, kd);
            chk((kd == 0) ? "midreset_kd0" : "midreset_kd2", (kd == 0) ? 10 : 15);
        end

        // Gain change mid-stream takes effect without a flush
        step(1, 1, 50, 40, 15, 0);
        chk("gain_change", 37);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 3) ? 1'b0 : 1'b1,
                 ($urandom_range(99) < 75) ? 1'b1 : 1'b0,
                 $urandom_range(255), $urandom_range(255),
                 $urandom_range(15), $urandom_range(15));
        end

        repeat (3) @(posedge CLK);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: pending=%0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
